// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop synchroniser, mid-bit sampling, one-cycle o_valid / o_frame_err strobes.
// Byte strobed ~2+HALF+9*TICKS_PER_BIT+1 cycles after the start edge; no backpressure, o_data is overwritten by the next good frame.
module uart_rx #(
  parameter int TICKS_PER_BIT      = 243,
  parameter int TICKS_PER_BIT_SIZE = 8
) (
  input  logic       i_clk,
  input  logic       in_rst,
  input  logic       i_rx,
  output logic [7:0] o_data,
  output logic       o_valid,
  output logic       o_frame_err,
  output logic       o_busy
);

  localparam int HALF = TICKS_PER_BIT / 2;
  localparam logic [TICKS_PER_BIT_SIZE-1:0] HALF_LAST = TICKS_PER_BIT_SIZE'(HALF - 1);
  localparam logic [TICKS_PER_BIT_SIZE-1:0] BIT_LAST  = TICKS_PER_BIT_SIZE'(TICKS_PER_BIT - 1);
  localparam logic [TICKS_PER_BIT_SIZE-1:0] TICK_ONE  = TICKS_PER_BIT_SIZE'(1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    DONE  = 3'd4,
    ERR   = 3'd5
  } state_t;

  state_t                        r_state;
  logic                          r_rx_meta;
  logic                          r_rx_s;
  logic [TICKS_PER_BIT_SIZE-1:0] r_tick;
  logic [2:0]                    r_bit;
  logic [7:0]                    r_shift;
  logic [7:0]                    r_data;
  logic                          r_valid;
  logic                          r_frame_err;
  logic                          r_busy;

  logic                          w_half_end;
  logic                          w_bit_end;

  assign w_half_end = (r_tick == HALF_LAST);
  assign w_bit_end  = (r_tick == BIT_LAST);

  // i_rx is asynchronous; nothing downstream may look at it directly.
  always_ff @(posedge i_clk or negedge in_rst) begin
    if (!in_rst) begin
      r_rx_meta <= 1'b1;
      r_rx_s    <= 1'b1;
    end else begin
      r_rx_meta <= i_rx;
      r_rx_s    <= r_rx_meta;
    end
  end

  always_ff @(posedge i_clk or negedge in_rst) begin
    if (!in_rst) begin
      r_state     <= IDLE;
      r_tick      <= '0;
      r_bit       <= '0;
      r_shift     <= '0;
      r_data      <= '0;
      r_valid     <= 1'b0;
      r_frame_err <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_valid     <= 1'b0;
      r_frame_err <= 1'b0;
      case (r_state)
        IDLE: begin
          r_tick <= '0;
          if (!r_rx_s) begin
            r_state <= START;
            r_busy  <= 1'b1;
          end
        end
        START: begin
          if (w_half_end) begin
            r_tick <= '0;
            r_bit  <= '0;
            // A line back high at mid-start is a glitch, not a frame.
            if (!r_rx_s) begin
              r_state <= DATA;
            end else begin
              r_state <= IDLE;
              r_busy  <= 1'b0;
            end
          end else begin
            r_tick <= r_tick + TICK_ONE;
          end
        end
        DATA: begin
          if (w_bit_end) begin
            r_tick  <= '0;
            r_shift <= {r_rx_s, r_shift[7:1]};
            r_bit   <= r_bit + 3'd1;
            if (r_bit == 3'd7) begin
              r_state <= STOP;
            end
          end else begin
            r_tick <= r_tick + TICK_ONE;
          end
        end
        STOP: begin
          if (w_bit_end) begin
            r_tick <= '0;
            if (r_rx_s) begin
              r_state <= DONE;
              r_data  <= r_shift;
              r_valid <= 1'b1;
            end else begin
              r_state     <= ERR;
              r_frame_err <= 1'b1;
            end
          end else begin
            r_tick <= r_tick + TICK_ONE;
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
        ERR: begin
          // Wait out a break / stuck-low line before hunting for a new start.
          if (r_rx_s) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= IDLE;
          r_tick  <= '0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign o_data      = r_data;
  assign o_valid     = r_valid;
  assign o_frame_err = r_frame_err;
  assign o_busy      = r_busy;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: one instance at 16 ticks/bit, one at the default 243 ticks/bit.
module tb_uart_rx;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx16;
  logic       rx243;
  logic [7:0] data16, data243;
  logic       valid16, valid243;
  logic       ferr16, ferr243;
  logic       busy16, busy243;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  uart_rx #(.TICKS_PER_BIT(16), .TICKS_PER_BIT_SIZE(5)) dut16 (
    .i_clk(clk), .in_rst(rst_n), .i_rx(rx16),
    .o_data(data16), .o_valid(valid16), .o_frame_err(ferr16), .o_busy(busy16)
  );

  uart_rx dut243 (
    .i_clk(clk), .in_rst(rst_n), .i_rx(rx243),
    .o_data(data243), .o_valid(valid243), .o_frame_err(ferr243), .o_busy(busy243)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int         vcnt16 = 0, fcnt16 = 0, bcnt16 = 0, both_cnt = 0;
  int         vcnt243 = 0, fcnt243 = 0;
  int         t_valid16 = 0;
  logic [7:0] hist16 [64];
  logic [7:0] last243 = 8'h00;

  always @(negedge clk) begin
    if (valid16) begin
      hist16[vcnt16[5:0]] = data16;
      t_valid16 = cyc;
      vcnt16++;
    end
    if (ferr16) fcnt16++;
    if (busy16) bcnt16++;
    if ((valid16 && ferr16) || (valid243 && ferr243)) both_cnt++;
    if (valid243) begin
      last243 = data243;
      vcnt243++;
    end
    if (ferr243) fcnt243++;
  end

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  int t_edge = 0;

  task automatic drive_bit(input bit sel, input logic v, input int n);
    @(negedge clk);
    if (sel) rx243 = v;
    else     rx16  = v;
    t_edge = cyc;
    repeat (n - 1) @(negedge clk);
  endtask

  int t_start = 0;

  task automatic send_frame(input bit sel, input logic [7:0] b, input int n, input logic stop_v);
    drive_bit(sel, 1'b0, n);
    t_start = t_edge;
    for (int i = 0; i < 8; i++) drive_bit(sel, b[i], n);
    drive_bit(sel, stop_v, n);
  endtask

  initial begin
    int v0, f0, b0, i1, lat;
    logic [7:0] b5a;

    rst_n = 1'b0;
    rx16  = 1'b1;
    rx243 = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("rst_data16",  int'(data16),  0);
    check_eq("rst_valid16", int'(valid16), 0);
    check_eq("rst_ferr16",  int'(ferr16),  0);
    check_eq("rst_busy16",  int'(busy16),  0);
    check_eq("rst_data243", int'(data243), 0);
    check_eq("rst_busy243", int'(busy243), 0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // Clean A5 frame; nominal latency 2+8+144+1 = 155
    v0 = vcnt16; f0 = fcnt16;
    send_frame(1'b0, 8'hA5, 16, 1'b1);
    drive_bit(1'b0, 1'b1, 20);
    check_eq("a5_valid_cnt", vcnt16 - v0, 1);
    check_eq("a5_data", int'(hist16[v0[5:0]]), 'hA5);
    check_eq("a5_ferr_cnt", fcnt16 - f0, 0);
    check_eq("a5_busy_after", int'(busy16), 0);
    lat = t_valid16 - t_start;
    check_eq("a5_latency_in_154_156", int'(lat >= 154 && lat <= 156), 1);

    // Back-to-back 00 then FF
    v0 = vcnt16; f0 = fcnt16;
    send_frame(1'b0, 8'h00, 16, 1'b1);
    send_frame(1'b0, 8'hFF, 16, 1'b1);
    drive_bit(1'b0, 1'b1, 20);
    i1 = v0 + 1;
    check_eq("b2b_valid_cnt", vcnt16 - v0, 2);
    check_eq("b2b_first", int'(hist16[v0[5:0]]), 'h00);
    check_eq("b2b_second", int'(hist16[i1[5:0]]), 'hFF);
    check_eq("b2b_ferr_cnt", fcnt16 - f0, 0);

    // 4-cycle low glitch while idle
    v0 = vcnt16; f0 = fcnt16; b0 = bcnt16;
    drive_bit(1'b0, 1'b0, 4);
    drive_bit(1'b0, 1'b1, 30);
    check_eq("glitch_valid_cnt", vcnt16 - v0, 0);
    check_eq("glitch_ferr_cnt", fcnt16 - f0, 0);
    check_eq("glitch_busy_8_10", int'((bcnt16 - b0) >= 8 && (bcnt16 - b0) <= 10), 1);
    check_eq("glitch_busy_after", int'(busy16), 0);
    check_eq("glitch_data_kept", int'(data16), 'hFF);

    // 3C with low stop bit, line then held low for 40 cycles
    v0 = vcnt16; f0 = fcnt16;
    send_frame(1'b0, 8'h3C, 16, 1'b0);
    drive_bit(1'b0, 1'b0, 40);
    check_eq("ferr_busy_held", int'(busy16), 1);
    drive_bit(1'b0, 1'b1, 10);
    check_eq("ferr_pulse_cnt", fcnt16 - f0, 1);
    check_eq("ferr_valid_cnt", vcnt16 - v0, 0);
    check_eq("ferr_data_kept", int'(data16), 'hFF);
    check_eq("ferr_busy_after", int'(busy16), 0);

    // Reset during data bit 4 of 5A
    b5a = 8'h5A;
    drive_bit(1'b0, 1'b0, 16);
    for (int i = 0; i < 4; i++) drive_bit(1'b0, b5a[i], 16);
    drive_bit(1'b0, b5a[4], 8);
    check_eq("mid_busy_before_rst", int'(busy16), 1);
    rst_n = 1'b0;
    rx16  = 1'b1;
    #1;
    check_eq("async_rst_busy", int'(busy16), 0);
    check_eq("async_rst_data", int'(data16), 0);
    check_eq("async_rst_valid", int'(valid16), 0);
    check_eq("async_rst_ferr", int'(ferr16), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    v0 = vcnt16;
    drive_bit(1'b0, 1'b1, 40);
    check_eq("post_rst_no_strobe", vcnt16 - v0, 0);
    send_frame(1'b0, 8'hC3, 16, 1'b1);
    drive_bit(1'b0, 1'b1, 20);
    check_eq("c3_valid_cnt", vcnt16 - v0, 1);
    check_eq("c3_data", int'(data16), 'hC3);

    // Default timing, bit period +3% / nominal / -3%
    v0 = vcnt243; f0 = fcnt243;
    send_frame(1'b1, 8'h81, 250, 1'b1);
    drive_bit(1'b1, 1'b1, 300);
    check_eq("slow_valid_cnt", vcnt243 - v0, 1);
    check_eq("slow_data", int'(last243), 'h81);
    send_frame(1'b1, 8'h7E, 243, 1'b1);
    drive_bit(1'b1, 1'b1, 300);
    check_eq("nom_data", int'(last243), 'h7E);
    send_frame(1'b1, 8'h81, 236, 1'b1);
    drive_bit(1'b1, 1'b1, 300);
    check_eq("fast_valid_cnt", vcnt243 - v0, 3);
    check_eq("fast_data", int'(last243), 'h81);
    check_eq("d243_ferr_cnt", fcnt243 - f0, 0);

    check_eq("valid_ferr_overlap", both_cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- UART receiver; the receive-side counterpart of the tester's UART transmitter. Uses the same bit timing, so both ends share one baud configuration.
- Deserialises 8N1 frames: start bit low, 8 data bits LSB first, 1 stop bit high, idle line high.
- Presents each received byte with a one-cycle valid strobe to the tester control logic.
- Detects false start bits and framing errors.

Parameters:
- TICKS_PER_BIT, 243: i_clk cycles per UART bit; must be >= 4.
- TICKS_PER_BIT_SIZE, 8: width of the tick counter; must satisfy 2^TICKS_PER_BIT_SIZE > TICKS_PER_BIT.

Ports:
- i_clk  input  1  system clock.
- in_rst  input  1  asynchronous active-low reset.
- i_rx  input  1  serial line; asynchronous to i_clk; idle high.
- o_data  output  8  last correctly received byte.
- o_valid  output  1  one-cycle pulse: o_data has been updated.
- o_frame_err  output  1  one-cycle pulse: stop bit was sampled low.
- o_busy  output  1  high while a frame is being received (any state other than IDLE).

Behaviour:
- Reset (in_rst low, asynchronous):
  - state = IDLE; o_data = 8'h00; o_valid = 0; o_frame_err = 0; o_busy = 0.
  - Both synchroniser flops = 1; tick counter = 0; bit counter = 0.
- Input synchroniser:
  - i_rx passes through 2 flops to give rx_s; all logic uses rx_s only.
  - rx_s lags i_rx by 2 cycles.
- HALF = TICKS_PER_BIT/2, integer floor.
- States: IDLE, START, DATA, STOP, DONE, ERR.
  - IDLE: tick counter held at 0. rx_s == 0 -> START.
  - START:
    - Tick counter counts 0..HALF-1.
    - At count HALF-1, sample rx_s. If 0 -> DATA, with tick counter and bit counter cleared. If 1 (false start / glitch) -> IDLE; no strobe.
  - DATA:
    - Tick counter counts 0..TICKS_PER_BIT-1 and wraps to 0.
    - At count TICKS_PER_BIT-1, rx_s is shifted into the MSB of the shift register (right shift, so the first bit ends in bit 0) and the bit counter increments.
    - After the 8th sample -> STOP, with tick counter cleared.
  - STOP:
    - Same timing as one DATA bit; rx_s is sampled at count TICKS_PER_BIT-1.
    - Sample 1 -> DONE. Sample 0 -> ERR.
  - DONE:
    - Exactly one cycle.
    - o_data <= shift register and o_valid = 1 in this cycle.
    - -> IDLE.
  - ERR:
    - o_frame_err = 1 on the first ERR cycle only; o_data is unchanged.
    - Stays in ERR until rx_s == 1, then -> IDLE. This covers a break condition or line held low.
- o_valid and o_frame_err are registered, never both high, and each lasts exactly 1 cycle per frame.
- o_busy = 1 in START, DATA, STOP, DONE and ERR.
- Sampling point is mid-bit. Nominal latency from the i_rx falling edge of the start bit to o_valid high is 2 + HALF + 9*TICKS_PER_BIT + 1 cycles (±1 for synchroniser phase).
- Back-to-back frames:
  - A new start bit may begin immediately after the stop bit.
  - The FSM reaches IDLE within HALF + 2 cycles of the stop-bit midpoint, so a start edge in the second half of the stop bit is detected without loss.
- o_data holds its value until the next valid frame; no consumer handshake, no overrun detection.
- Reset asserted mid-frame aborts immediately to the reset values. After release, a partially received frame yields no strobe; the line must be seen low again from IDLE.
- Counter arithmetic is unsigned at TICKS_PER_BIT_SIZE width and never wraps beyond TICKS_PER_BIT-1.

Test Plan:
- TICKS_PER_BIT = 16, send byte 8'hA5 as a clean 8N1 frame -> exactly one o_valid pulse, o_data = 8'hA5, o_frame_err never high, o_busy low after DONE.
- Two back-to-back frames 8'h00 then 8'hFF, with the second start bit immediately after the first stop bit -> two o_valid pulses, with o_data = 8'h00 then 8'hFF.
- Low glitch on i_rx of 4 cycles while idle -> return to IDLE at the half-bit check, no o_valid, no o_frame_err, o_busy high for about HALF+1 cycles.
- Frame 8'h3C with the stop bit driven low, then the line held low for 40 cycles and released -> one o_frame_err pulse, no o_valid, o_data retains its previous value, o_busy stays high until rx_s returns to 1.
- in_rst pulsed low during data bit 4 of frame 8'h5A -> all outputs return to reset values asynchronously. The following clean frame 8'hC3 is received correctly with o_data = 8'hC3.
- Default TICKS_PER_BIT = 243 with the bit period stretched and shrunk by 3% across frame 8'h81 -> o_data = 8'h81 in both cases.
